prbs_checker: RTL and testbench
===============================

Name: prbs_checker

Overview:
- Serial receive-side checker for the ALSU bench/debug path. It samples a serial bit stream, such as the output of a D flip-flop or other registered path, and self-synchronises a PRBS7 reference to it.
- It then flags every bit that differs from the predicted sequence, counts errors and reports lock status.
- It is the reader/checker end of a random-bit stimulus source: the source writes pseudo-random bits into the path, and this block verifies them in hardware.

Parameters:
- LOCK_CNT, 8: consecutive correct predictions needed in HUNT before declaring lock.
- LOSS_THRESH, 4: consecutive mispredictions in LOCKED that drop lock.
- ERR_CNT_W, 16: width of the saturating error counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  din is valid this cycle; when low, no state changes.
- din  input  1  serial data bit under test.
- clr_cnt  input  1  synchronous clear of err_count.
- locked  output  1  high while FSM is in LOCKED.
- err_pulse  output  1  one-cycle flag: the last accepted bit mismatched while LOCKED.
- err_count  output  ERR_CNT_W  saturating count of mismatches seen while LOCKED.

Behaviour:
- Reset (async, immediate, including mid-operation):
  - State = SEED; 7-bit shift register s = 0; fill/match/consecutive-error counters = 0.
  - Outputs: locked = 0, err_pulse = 0, err_count = 0.
- Polynomial: x^7 + x^6 + 1. Predicted bit p = s[6] ^ s[5]. Shift direction is always s <= {s[5:0], x}.
- When en = 0: s, the FSM and all counters hold; err_pulse = 0 in the following cycle.
- SEED state:
  - On each en, s <= {s[5:0], din} and fill count increments.
  - On the 7th accepted bit, go to HUNT with match count = 0.
- HUNT state:
  - On each en, s <= {s[5:0], din}.
  - If din == p and s != 0, match count increments; otherwise match count = 0.
  - The all-zero guard prevents false lock on a stuck-at-0 stream.
  - When match count reaches LOCK_CNT, go to LOCKED with consecutive-error count = 0.
- LOCKED state:
  - On each en, s <= {s[5:0], p}. The reference free-runs, so input errors are not re-injected and do not multiply.
  - If din != p: err_pulse = 1 for exactly the next cycle, err_count increments (saturating at all-ones), and consecutive-error count increments.
  - If din == p: consecutive-error count = 0.
  - When consecutive-error count reaches LOSS_THRESH (on that same edge): go to SEED, clear fill count, locked = 0.
  - The LOSS_THRESH-th error itself still pulses err_pulse and is counted.
- locked is decoded directly from the state register, so it is glitch-free and changes on the edge that accepts the deciding bit.
- Lock latency: with a clean stream and default parameters, locked rises on the edge that accepts the 15th valid bit (7 seed + 8 match).
- clr_cnt: err_count = 0 on the next edge.
  - If clr_cnt and a counted error occur on the same edge, clear wins and err_count = 0.
  - clr_cnt does not affect err_pulse, state or lock.
- err_count is not cleared by loss of lock; only rst or clr_cnt clears it.

Test Plan:
- Clean stream: rst for 10 ns, then a PRBS7 stream from seed 7'h7F with en = 1 every cycle -> locked rises after the 15th bit's edge; err_count = 0 and err_pulse never asserts over 254 bits.
- Single error: after lock, invert bit 50 -> exactly one err_pulse cycle (the cycle after that edge), err_count = 1, locked stays 1, and the next 100 bits produce no errors.
- Gapped input: same stream with en randomly low for about 40% of cycles -> identical lock point counted in valid bits, err_count = 0, and no change while en = 0.
- Stuck-at-zero: din = 0 for 200 cycles with en = 1 -> locked never asserts and err_count stays 0.
- Loss of lock: after lock, invert 4 consecutive bits -> err_count = 4, four err_pulse cycles, and locked falls on the 4th error's edge. Clean data then resumes from the current generator state -> locked rises 15 valid bits later.
- Counter saturation and clear: build with ERR_CNT_W = 4 and inject 20 isolated single-bit errors, each separated by at least 10 good bits -> err_count saturates at 15. Then assert clr_cnt on the same edge as a further error -> err_count = 0.
- Asynchronous reset mid-lock: assert rst while locked -> locked = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/prbs_checker.sv
// PRBS7 (x^7 + x^6 + 1) receive checker: self-synchronises a reference
// to the incoming serial stream, then flags, counts and tracks lock on mismatches.
module prbs_checker #(
  parameter int LOCK_CNT    = 8,
  parameter int LOSS_THRESH = 4,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 din,
  input  logic                 clr_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int LOSS_W  = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [6:0]           s_reg, s_next;
  logic [2:0]           fill_reg, fill_next;
  logic [MATCH_W-1:0]   match_reg, match_next;
  logic [LOSS_W-1:0]    loss_reg, loss_next;
  logic                 err_pulse_reg, err_pulse_next;
  logic [ERR_CNT_W-1:0] err_count_reg, err_count_next;

  logic                 pred;
  logic                 mismatch;
  logic [MATCH_W-1:0]   match_inc;
  logic [LOSS_W-1:0]    loss_inc;

  assign pred      = s_reg[6] ^ s_reg[5];
  assign mismatch  = din ^ pred;
  assign match_inc = match_reg + MATCH_W'(1);
  assign loss_inc  = loss_reg + LOSS_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= SEED;
      s_reg         <= '0;
      fill_reg      <= '0;
      match_reg     <= '0;
      loss_reg      <= '0;
      err_pulse_reg <= 1'b0;
      err_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      s_reg         <= s_next;
      fill_reg      <= fill_next;
      match_reg     <= match_next;
      loss_reg      <= loss_next;
      err_pulse_reg <= err_pulse_next;
      err_count_reg <= err_count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    s_next         = s_reg;
    fill_next      = fill_reg;
    match_next     = match_reg;
    loss_next      = loss_reg;
    err_pulse_next = 1'b0;
    err_count_next = err_count_reg;

    if (en) begin
      case (state_reg)
        SEED: begin
          s_next    = {s_reg[5:0], din};
          fill_next = fill_reg + 3'd1;
          if (fill_reg == 3'd6) begin
            state_next = HUNT;
            fill_next  = '0;
            match_next = '0;
          end
        end

        HUNT: begin
          s_next = {s_reg[5:0], din};
          // An all-zero window predicts zero forever; never count it as a match.
          if (!mismatch && (s_reg != 7'd0)) begin
            match_next = match_inc;
            if (match_inc == MATCH_W'(LOCK_CNT)) begin
              state_next = LOCKED;
              match_next = '0;
              loss_next  = '0;
            end
          end else begin
            match_next = '0;
          end
        end

        LOCKED: begin
          // Reference free-runs on its own prediction so line errors do not propagate.
          s_next = {s_reg[5:0], pred};
          if (mismatch) begin
            err_pulse_next = 1'b1;
            if (err_count_reg != {ERR_CNT_W{1'b1}})
              err_count_next = err_count_reg + ERR_CNT_W'(1);
            loss_next = loss_inc;
            if (loss_inc == LOSS_W'(LOSS_THRESH)) begin
              state_next = SEED;
              fill_next  = '0;
              loss_next  = '0;
            end
          end else begin
            loss_next = '0;
          end
        end

        default: begin
          state_next = SEED;
          fill_next  = '0;
        end
      endcase
    end

    if (clr_cnt)
      err_count_next = '0;
  end

  assign locked    = (state_reg == LOCKED);
  assign err_pulse = err_pulse_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a reference PRBS7 source drives two
// instances (default counter width and a 4-bit counter for saturation).
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        din;
  logic        clr_cnt;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic        locked4, err_pulse4;
  logic [3:0]  err_count4;

  logic [6:0]  g;
  int          asserts = 0;
  int          fails   = 0;

  always #5 clk = ~clk;

  prbs_checker u_dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
  );

  prbs_checker #(.ERR_CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
    .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4)
  );

  task automatic next_bit(output logic b);
    b = g[6] ^ g[5];
    g = {g[5:0], b};
  endtask

  task automatic step(input logic d, input logic e, input logic c);
    din = d; en = e; clr_cnt = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; din = 1'b0; clr_cnt = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    g = 7'h7F;
  endtask

  // Feed n clean bits from the reference source.
  task automatic send_clean(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      next_bit(b);
      step(b, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    asserts++;
    if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_state: locked=%b err_pulse=%b err_count=%0d, required 0/0/0",
               locked, err_pulse, err_count);
    end
    $display("test_reset: locked=%b err_pulse=%b err_count=%0d", locked, err_pulse, err_count);
  endtask

  task automatic test_clean();
    logic b;
    int   pulses = 0;
    do_reset();
    for (int i = 1; i <= 254; i++) begin
      next_bit(b);
      step(b, 1'b1, 1'b0);
      if (err_pulse) pulses++;
      if (i == 14) begin
        asserts++;
        if (locked !== 1'b0) begin
          fails++;
          $display("FAIL clean_lock_early: locked=%b after bit 14, required 0", locked);
        end
      end
      if (i == 15) begin
        asserts++;
        if (locked !== 1'b1) begin
          fails++;
          $display("FAIL clean_lock_point: locked=%b after bit 15, required 1", locked);
        end
      end
    end
    asserts++;
    if (pulses != 0 || err_count !== 16'd0 || locked !== 1'b1) begin
      fails++;
      $display("FAIL clean_stream: pulses=%0d err_count=%0d locked=%b, required 0/0/1",
               pulses, err_count, locked);
    end
    $display("test_clean: 254 bits, pulses=%0d err_count=%0d locked=%b", pulses, err_count, locked);
  endtask

  task automatic test_single_error();
    logic b;
    int   pulses = 0;
    do_reset();
    for (int i = 1; i <= 150; i++) begin
      next_bit(b);
      step((i == 50) ? ~b : b, 1'b1, 1'b0);
      if (i == 49 || i == 50 || i == 51) begin
        asserts++;
        if (err_pulse !== (i == 50)) begin
          fails++;
          $display("FAIL single_err_pulse: bit %0d err_pulse=%b, required %b", i, err_pulse, (i == 50));
        end
      end
      if (i > 50 && err_pulse) pulses++;
    end
    asserts++;
    if (err_count !== 16'd1 || locked !== 1'b1 || pulses != 0) begin
      fails++;
      $display("FAIL single_err_count: err_count=%0d locked=%b later_pulses=%0d, required 1/1/0",
               err_count, locked, pulses);
    end
    $display("test_single_error: err_count=%0d locked=%b", err_count, locked);
  endtask

  task automatic test_gapped();
    logic        b, e, prev_locked;
    logic [15:0] prev_count;
    int          valid = 0;
    int          cycles = 0;
    int          pulses = 0;
    do_reset();
    while (valid < 254 && cycles < 2000) begin
      cycles++;
      e = ($urandom_range(0, 9) >= 4);
      prev_locked = locked;
      prev_count  = err_count;
      if (e) begin
        next_bit(b);
        valid++;
      end else begin
        b = $urandom_range(0, 1);
      end
      step(b, e, 1'b0);
      if (err_pulse) pulses++;
      if (!e) begin
        asserts++;
        if (locked !== prev_locked || err_count !== prev_count || err_pulse !== 1'b0) begin
          fails++;
          $display("FAIL gap_hold: locked %b->%b err_count %0d->%0d err_pulse=%b, required no change",
                   prev_locked, locked, prev_count, err_count, err_pulse);
        end
      end else if (valid == 14 || valid == 15) begin
        asserts++;
        if (locked !== (valid == 15)) begin
          fails++;
          $display("FAIL gap_lock_point: valid bit %0d locked=%b, required %b", valid, locked, (valid == 15));
        end
      end
    end
    asserts++;
    if (valid != 254 || pulses != 0 || err_count !== 16'd0 || locked !== 1'b1) begin
      fails++;
      $display("FAIL gapped_stream: valid=%0d pulses=%0d err_count=%0d locked=%b, required 254/0/0/1",
               valid, pulses, err_count, locked);
    end
    $display("test_gapped: %0d cycles, %0d valid bits, err_count=%0d locked=%b", cycles, valid, err_count, locked);
  endtask

  task automatic test_stuck_zero();
    int seen = 0;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (locked) seen++;
    end
    asserts++;
    if (seen != 0 || err_count !== 16'd0) begin
      fails++;
      $display("FAIL stuck_zero: locked cycles=%0d err_count=%0d, required 0/0", seen, err_count);
    end
    $display("test_stuck_zero: locked cycles=%0d err_count=%0d", seen, err_count);
  endtask

  task automatic test_loss_of_lock();
    logic b;
    do_reset();
    send_clean(25);
    for (int k = 1; k <= 4; k++) begin
      next_bit(b);
      step(~b, 1'b1, 1'b0);
      asserts++;
      if (err_pulse !== 1'b1 || locked !== (k < 4) || err_count !== 16'(k)) begin
        fails++;
        $display("FAIL loss_error_%0d: err_pulse=%b locked=%b err_count=%0d, required 1/%b/%0d",
                 k, err_pulse, locked, err_count, (k < 4), k);
      end
    end
    for (int k = 1; k <= 15; k++) begin
      next_bit(b);
      step(b, 1'b1, 1'b0);
      if (k == 14 || k == 15) begin
        asserts++;
        if (locked !== (k == 15)) begin
          fails++;
          $display("FAIL relock_point: bit %0d after loss locked=%b, required %b", k, locked, (k == 15));
        end
      end
    end
    asserts++;
    if (err_count !== 16'd4) begin
      fails++;
      $display("FAIL loss_count_kept: err_count=%0d, required 4", err_count);
    end
    $display("test_loss_of_lock: err_count=%0d locked=%b", err_count, locked);
  endtask

  task automatic test_saturation();
    logic b;
    do_reset();
    send_clean(15);
    for (int k = 0; k < 20; k++) begin
      send_clean(10);
      next_bit(b);
      step(~b, 1'b1, 1'b0);
    end
    asserts++;
    if (err_count4 !== 4'd15 || err_count !== 16'd20 || locked !== 1'b1 || locked4 !== 1'b1) begin
      fails++;
      $display("FAIL saturation: err_count4=%0d err_count=%0d locked=%b/%b, required 15/20/1/1",
               err_count4, err_count, locked, locked4);
    end
    send_clean(10);
    next_bit(b);
    step(~b, 1'b1, 1'b1);
    asserts++;
    if (err_count4 !== 4'd0 || err_count !== 16'd0 || err_pulse4 !== 1'b1 || locked4 !== 1'b1) begin
      fails++;
      $display("FAIL clear_wins: err_count4=%0d err_count=%0d err_pulse4=%b locked4=%b, required 0/0/1/1",
               err_count4, err_count, err_pulse4, locked4);
    end
    $display("test_saturation: after clear err_count4=%0d err_count=%0d", err_count4, err_count);
  endtask

  task automatic test_async_reset();
    logic b;
    do_reset();
    send_clean(20);
    next_bit(b);
    step(~b, 1'b1, 1'b0);
    send_clean(3);
    asserts++;
    if (locked !== 1'b1 || err_count !== 16'd1) begin
      fails++;
      $display("FAIL async_pre: locked=%b err_count=%0d, required 1/1", locked, err_count);
    end
    #2;
    rst = 1'b1;
    #1;
    asserts++;
    if (locked !== 1'b0 || err_count !== 16'd0 || err_pulse !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: locked=%b err_count=%0d err_pulse=%b, required 0/0/0",
               locked, err_count, err_pulse);
    end
    $display("test_async_reset: mid-cycle locked=%b err_count=%0d", locked, err_count);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; din = 1'b0; clr_cnt = 1'b0; g = 7'h7F;
    test_reset();
    test_clean();
    test_single_error();
    test_gapped();
    test_stuck_zero();
    test_loss_of_lock();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
